// File: rtl/pwm_pkg.sv
// Shared constants for the PWM register bank: address map, CTRL bit positions
// and register width.
package pwm_pkg;
   localparam int REG_W = 8;

   localparam logic [1:0] ADDR_CTRL     = 2'd0;
   localparam logic [1:0] ADDR_PERIOD   = 2'd1;
   localparam logic [1:0] ADDR_DUTY     = 2'd2;
   localparam logic [1:0] ADDR_PRESCALE = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_POL = 1;
endpackage

// File: rtl/pwm_regbank_if.sv
// Register-access bus between the SPI slave (master side) and the PWM
// register bank (slave side). data_rd is combinational from addr.
interface pwm_regbank_if;
   import pwm_pkg::*;

   logic [1:0]       addr;
   logic [REG_W-1:0] data_wr;
   logic             wr_en;
   logic [REG_W-1:0] data_rd;

   modport master (output addr, output data_wr, output wr_en, input data_rd);
   modport slave  (input addr, input data_wr, input wr_en, output data_rd);
endinterface

// File: rtl/pwm_core.sv
// PWM engine: prescaler, period counter, active register copies and output flop.
// Optional PWM_IRQ_EN adds a one-clk irq pulse aligned with the first cnt=0 output.
module pwm_core
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_pol,
   input  logic [REG_W-1:0] i_period,
   input  logic [REG_W-1:0] i_duty,
   input  logic [REG_W-1:0] i_presc,
`ifdef PWM_IRQ_EN
   output logic             o_irq,
`endif
   output logic             o_pwm_out
);

   logic [REG_W-1:0] r_period_a;
   logic [REG_W-1:0] r_duty_a;
   logic [REG_W-1:0] r_presc_a;
   logic [REG_W-1:0] r_presc_cnt;
   logic [REG_W-1:0] r_cnt;
   logic             r_pwm;
   logic             w_tick;
   logic             w_wrap;
   logic             w_raw;

   assign w_tick = (r_presc_cnt == r_presc_a);
   assign w_wrap = i_en & w_tick & (r_cnt == r_period_a);
   assign w_raw  = i_en & (r_cnt < r_duty_a);

   // Active copies track the programmed values while idle and only at wrap
   // while running, so mid-period writes never disturb the current period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_period_a  <= '0;
         r_duty_a    <= '0;
         r_presc_a   <= '0;
         r_presc_cnt <= '0;
         r_cnt       <= '0;
         r_pwm       <= 1'b0;
      end else begin
         r_pwm <= w_raw ^ i_pol;
         if (!i_en) begin
            r_presc_cnt <= '0;
            r_cnt       <= '0;
            r_period_a  <= i_period;
            r_duty_a    <= i_duty;
            r_presc_a   <= i_presc;
         end else if (w_tick) begin
            r_presc_cnt <= '0;
            if (w_wrap) begin
               r_cnt      <= '0;
               r_period_a <= i_period;
               r_duty_a   <= i_duty;
               r_presc_a  <= i_presc;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end else begin
            r_presc_cnt <= r_presc_cnt + 8'd1;
         end
      end
   end

   assign o_pwm_out = r_pwm;

`ifdef PWM_IRQ_EN
   logic r_wrap_d;
   logic r_irq;

   // Delayed one extra clk so the pulse lines up with the cnt=0 output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrap_d <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_wrap_d <= w_wrap;
         r_irq    <= r_wrap_d;
      end
   end

   assign o_irq = r_irq;
`endif

endmodule

// File: rtl/pwm_regbank.sv
// PWM register bank: CTRL/PERIOD/DUTY/PRESCALE file with edge-detected writes
// and a combinational read mux. Define PWM_IRQ_EN to get the o_irq output.
module pwm_regbank
   import pwm_pkg::*;
#(
   parameter logic [REG_W-1:0] RST_PERIOD   = 8'hFF,
   parameter logic [REG_W-1:0] RST_DUTY     = 8'h80,
   parameter logic [REG_W-1:0] RST_PRESCALE = 8'h00
)(
   input  logic         clk,
   input  logic         rst_n,
   pwm_regbank_if.slave bus,
`ifdef PWM_IRQ_EN
   output logic         o_irq,
`endif
   output logic         o_pwm_out
);

   logic [1:0]       r_ctrl;
   logic [REG_W-1:0] r_period;
   logic [REG_W-1:0] r_duty;
   logic [REG_W-1:0] r_presc;
   logic             r_wr_en_q;
   logic             w_strobe;

   // wr_en is a level from the SPI slave; only its rising edge commits a write.
   assign w_strobe = bus.wr_en & ~r_wr_en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl    <= '0;
         r_period  <= RST_PERIOD;
         r_duty    <= RST_DUTY;
         r_presc   <= RST_PRESCALE;
         r_wr_en_q <= 1'b0;
      end else begin
         r_wr_en_q <= bus.wr_en;
         if (w_strobe) begin
            unique case (bus.addr)
               ADDR_CTRL:     r_ctrl   <= bus.data_wr[1:0];
               ADDR_PERIOD:   r_period <= bus.data_wr;
               ADDR_DUTY:     r_duty   <= bus.data_wr;
               ADDR_PRESCALE: r_presc  <= bus.data_wr;
            endcase
         end
      end
   end

   always_comb begin
      bus.data_rd = '0;
      unique case (bus.addr)
         ADDR_CTRL:     bus.data_rd = {6'b0, r_ctrl};
         ADDR_PERIOD:   bus.data_rd = r_period;
         ADDR_DUTY:     bus.data_rd = r_duty;
         ADDR_PRESCALE: bus.data_rd = r_presc;
      endcase
   end

   pwm_core u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (r_ctrl[CTRL_EN]),
      .i_pol     (r_ctrl[CTRL_POL]),
      .i_period  (r_period),
      .i_duty    (r_duty),
      .i_presc   (r_presc),
`ifdef PWM_IRQ_EN
      .o_irq     (o_irq),
`endif
      .o_pwm_out (o_pwm_out)
   );

endmodule

// File: tb/tb_pwm_regbank.sv
// Scoreboard bench for pwm_regbank: a time-based reference model predicts
// pwm_out (and irq when PWM_IRQ_EN is defined) and register read-back each cycle.
module tb_pwm_regbank;

   logic clk;
   logic rst_n;
   logic pwm_out;
`ifdef PWM_IRQ_EN
   logic irq;
`endif

   pwm_regbank_if bus ();

   pwm_regbank dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
`ifdef PWM_IRQ_EN
      .o_irq     (irq),
`endif
      .o_pwm_out (pwm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic pwm;
      logic irq;
   } exp_t;

   exp_t q_exp[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: programmed registers plus elapsed clocks inside the
   // current PWM period; cnt is derived as elapsed / (prescale + 1).
   logic [7:0] m_reg [4];
   logic       m_wrq;
   int         m_elapsed;
   int         a_per, a_duty, a_presc;
   logic       m_wrap_d;

   task automatic model_reset();
      m_reg[0] = 8'h00; m_reg[1] = 8'hFF; m_reg[2] = 8'h80; m_reg[3] = 8'h00;
      m_wrq = 1'b0; m_elapsed = 0; a_per = 0; a_duty = 0; a_presc = 0;
      m_wrap_d = 1'b0;
   endtask

   always @(posedge clk) begin
      exp_t e;
      if (!rst_n) begin
         model_reset();
         e.pwm = 1'b0;
         e.irq = 1'b0;
      end else begin
         logic en, pol, wrap;
         int   cnt;
         en  = m_reg[0][0];
         pol = m_reg[0][1];
         cnt = m_elapsed / (a_presc + 1);
         e.pwm = (en && (cnt < a_duty)) ^ pol;
         e.irq = m_wrap_d;
         wrap = 1'b0;
         if (!en) begin
            m_elapsed = 0;
            a_per = m_reg[1]; a_duty = m_reg[2]; a_presc = m_reg[3];
         end else if (m_elapsed + 1 == (a_per + 1) * (a_presc + 1)) begin
            m_elapsed = 0;
            a_per = m_reg[1]; a_duty = m_reg[2]; a_presc = m_reg[3];
            wrap = 1'b1;
         end else begin
            m_elapsed++;
         end
         m_wrap_d = wrap;
         if (bus.wr_en && !m_wrq)
            m_reg[bus.addr] = (bus.addr == 2'd0) ? (bus.data_wr & 8'h03) : bus.data_wr;
         m_wrq = bus.wr_en;
      end
      q_exp.push_back(e);
   end

   always @(negedge clk) begin
      if (q_exp.size() > 0) begin
         exp_t e;
         e = q_exp.pop_front();
         if (rst_n) begin
            n_vec++;
            if (pwm_out !== e.pwm) begin
               n_err++;
               $display("FAIL pwm_out: got %0b expected %0b at %0t", pwm_out, e.pwm, $time);
            end
            n_vec++;
            if (bus.data_rd !== m_reg[bus.addr]) begin
               n_err++;
               $display("FAIL data_rd[%0d]: got %02h expected %02h at %0t",
                        bus.addr, bus.data_rd, m_reg[bus.addr], $time);
            end
`ifdef PWM_IRQ_EN
            n_vec++;
            if (irq !== e.irq) begin
               n_err++;
               $display("FAIL irq: got %0b expected %0b at %0t", irq, e.irq, $time);
            end
`endif
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         cyc();
         bus.addr = 2'($urandom % 4);
      end
   endtask

   task automatic wr(input int a, input int d, input int hold);
      cyc();
      bus.addr    = 2'(a);
      bus.data_wr = 8'(d);
      bus.wr_en   = 1'b1;
      repeat (hold - 1) cyc();
      cyc();
      bus.wr_en = 1'b0;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, got, want);
      end
   endtask

   task automatic mid_reset();
      logic [7:0] dflt [4];
      dflt[0] = 8'h00; dflt[1] = 8'hFF; dflt[2] = 8'h80; dflt[3] = 8'h00;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("pwm_out in reset", {7'b0, pwm_out}, 8'h00);
      for (int a = 0; a < 4; a++) begin
         bus.addr = 2'(a);
         #1;
         chk("reset default", bus.data_rd, dflt[a]);
      end
      bus.wr_en = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.addr    = 2'd0;
      bus.data_wr = 8'h00;
      bus.wr_en   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Reset defaults read back on all addresses
      for (int a = 0; a < 4; a++) begin
         cyc();
         bus.addr = 2'(a);
      end
      idle(3);

      // Level wr_en held 20 cycles, data changes mid-assertion
      cyc();
      bus.addr = 2'd2; bus.data_wr = 8'h05; bus.wr_en = 1'b1;
      repeat (10) cyc();
      bus.data_wr = 8'h07;
      repeat (10) cyc();
      bus.wr_en = 1'b0;
      idle(3);

      // Basic PWM, then prescale 1
      wr(1, 9, 1); wr(2, 3, 2); wr(3, 0, 1); wr(0, 1, 3);
      idle(35);
      wr(3, 1, 1);
      idle(50);

      // Boundaries
      wr(3, 0, 1);
      wr(2, 0, 1);  idle(25);
      wr(2, 12, 1); idle(25);
      wr(1, 0, 1); wr(2, 1, 1); idle(15);
      wr(0, 2, 1);  idle(10);
      wr(0, 3, 1);  idle(10);

      // Glitch-free DUTY update mid-period
      wr(0, 0, 1); wr(1, 9, 1); wr(2, 3, 1); wr(0, 1, 1);
      idle(4);
      wr(2, 8, 1);
      idle(30);

`ifdef PWM_IRQ_EN
      wr(1, 4, 1); wr(2, 2, 1);
      idle(30);
`endif

      // Async reset mid-period with POL set
      wr(0, 3, 1);
      idle(7);
      mid_reset();
      idle(5);

      // Randomized register traffic
      for (int i = 0; i < 250; i++) begin
         int a, d;
         a = $urandom % 4;
         case (a)
            0: d = (($urandom % 4) != 0) ? ($urandom | 1) : $urandom;
            1: d = $urandom % 16;
            2: d = $urandom % 20;
            default: d = $urandom % 3;
         endcase
         if ($urandom % 16 == 0) d = $urandom % 256;
         if (a == 3 && d > 4) d = d % 4;
         wr(a, d, 1 + $urandom % 4);
         idle($urandom % 12);
      end

      mid_reset();
      idle(10);

      @(negedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
